// File: rtl/enc_sched_pkg.sv
// Shared types and defaults for the encoder pack scheduler.
package enc_sched_pkg;

  localparam int NUM_PACKS_DEF = 28;
  localparam int BIND_LAT_DEF  = 1;
  localparam int TAG_IDX_W     = 16;
  localparam int TAG_W         = TAG_IDX_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } enc_sched_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [TAG_IDX_W-1:0] idx;
  } enc_sched_tag_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enc_sched_valid_pipe.sv
// BIND_LAT-deep shift register of scheduler tags; flush clears every stage
// on the next edge so no in-flight result escapes after an abort.
module enc_sched_valid_pipe
  import enc_sched_pkg::*;
#(
  parameter int BIND_LAT = BIND_LAT_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  enc_sched_tag_t stage_q [BIND_LAT];
  enc_sched_tag_t stage_d [BIND_LAT];

  always_comb begin
    for (int i = 0; i < BIND_LAT; i++) begin
      stage_d[i] = '0;
    end
    if (!flush) begin
      stage_d[0] = enc_sched_tag_t'(tag_in);
      for (int i = 1; i < BIND_LAT; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < BIND_LAT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BIND_LAT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = TAG_W'(stage_q[BIND_LAT-1]);

endmodule

// File: rtl/enc_pack_scheduler.sv
// Issues one binder pack per cycle, tracks binder latency and flags accumulator
// valids. Optional ENC_SCHED_PERF_EN adds a saturating cycle_count output.
module enc_pack_scheduler
  import enc_sched_pkg::*;
#(
  parameter int NUM_PACKS  = NUM_PACKS_DEF,
  parameter int BIND_LAT   = BIND_LAT_DEF,
  parameter int PACK_IDX_W = idx_width(NUM_PACKS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic [PACK_IDX_W-1:0] pack_sel,
  output logic                  pack_start,
  output logic                  acc_en,
  output logic [PACK_IDX_W-1:0] acc_idx,
  output logic                  acc_last,
  output logic                  done
`ifdef ENC_SCHED_PERF_EN
  ,
  output logic [15:0]           cycle_count
`endif
);

  localparam logic [PACK_IDX_W-1:0] LAST_IDX = PACK_IDX_W'(NUM_PACKS - 1);

  enc_sched_state_t state_q, state_d;
  logic                  busy_q, busy_d;
  logic [PACK_IDX_W-1:0] pack_sel_q, pack_sel_d;
  logic                  pack_start_q, pack_start_d;
  logic                  done_q, done_d;
  logic                  pipe_flush;
  enc_sched_tag_t        tag_in, tag_out;
  logic [TAG_W-1:0]      tag_out_bits;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    pack_sel_d   = pack_sel_q;
    pack_start_d = 1'b0;
    done_d       = 1'b0;
    pipe_flush   = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      pipe_flush = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d      = ISSUE;
            busy_d       = 1'b1;
            pack_start_d = 1'b1;
            pack_sel_d   = '0;
          end
        end
        ISSUE: begin
          if (pack_sel_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            pack_start_d = 1'b1;
            pack_sel_d   = pack_sel_q + PACK_IDX_W'(1);
          end
        end
        // Completion keys off the registered last tag leaving the delay line.
        DRAIN: begin
          if (tag_out.valid && tag_out.last) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      pack_sel_q   <= '0;
      pack_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      pack_sel_q   <= pack_sel_d;
      pack_start_q <= pack_start_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    tag_in = '0;
    if (pack_start_q) begin
      tag_in.valid = 1'b1;
      tag_in.last  = (pack_sel_q == LAST_IDX);
      tag_in.idx   = TAG_IDX_W'(pack_sel_q);
    end
  end

  enc_sched_valid_pipe #(
    .BIND_LAT (BIND_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .nrst    (nrst),
    .flush   (pipe_flush),
    .tag_in  (TAG_W'(tag_in)),
    .tag_out (tag_out_bits)
  );

  assign tag_out = enc_sched_tag_t'(tag_out_bits);

  assign busy       = busy_q;
  assign pack_sel   = pack_sel_q;
  assign pack_start = pack_start_q;
  assign done       = done_q;
  assign acc_en     = tag_out.valid;
  assign acc_idx    = tag_out.idx[PACK_IDX_W-1:0];
  assign acc_last   = tag_out.last;

`ifdef ENC_SCHED_PERF_EN
  logic [15:0] cycle_count_q, cycle_count_d;

  // First busy cycle reads 1; DONE and abort freeze the value.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (state_q == IDLE) begin
      if (start && !abort) begin
        cycle_count_d = 16'd1;
      end
    end else if (!abort && (state_q != DONE) && (cycle_count_q != 16'hFFFF)) begin
      cycle_count_d = cycle_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      cycle_count_q <= 16'd0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_enc_pack_scheduler.sv
// Bench for enc_pack_scheduler: three instances (28/1, 4/3, 1/1 packs/latency),
// timing tables, corner sequences and an accumulator-tag scoreboard.
module tb_enc_pack_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst_a, start_a, abort_a, busy_a, ps_a, en_a, last_a, done_a;
  logic [4:0] sel_a, idx_a;
  logic nrst_bc, start_b, abort_b, busy_b, ps_b, en_b, last_b, done_b;
  logic [1:0] sel_b, idx_b;
  logic start_c, abort_c, busy_c, ps_c, en_c, last_c, done_c;
  logic [0:0] sel_c, idx_c;
`ifdef ENC_SCHED_PERF_EN
  logic [15:0] cc_a, cc_b, cc_c;
`endif

  enc_pack_scheduler #(.NUM_PACKS(28), .BIND_LAT(1)) u_dut_a (
    .clk(clk), .nrst(nrst_a), .start(start_a), .abort(abort_a), .busy(busy_a),
    .pack_sel(sel_a), .pack_start(ps_a), .acc_en(en_a), .acc_idx(idx_a),
    .acc_last(last_a), .done(done_a)
`ifdef ENC_SCHED_PERF_EN
    , .cycle_count(cc_a)
`endif
  );

  enc_pack_scheduler #(.NUM_PACKS(4), .BIND_LAT(3)) u_dut_b (
    .clk(clk), .nrst(nrst_bc), .start(start_b), .abort(abort_b), .busy(busy_b),
    .pack_sel(sel_b), .pack_start(ps_b), .acc_en(en_b), .acc_idx(idx_b),
    .acc_last(last_b), .done(done_b)
`ifdef ENC_SCHED_PERF_EN
    , .cycle_count(cc_b)
`endif
  );

  enc_pack_scheduler #(.NUM_PACKS(1), .BIND_LAT(1)) u_dut_c (
    .clk(clk), .nrst(nrst_bc), .start(start_c), .abort(abort_c), .busy(busy_c),
    .pack_sel(sel_c), .pack_start(ps_c), .acc_en(en_c), .acc_idx(idx_c),
    .acc_last(last_c), .done(done_c)
`ifdef ENC_SCHED_PERF_EN
    , .cycle_count(cc_c)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt [3];
  int acc_cnt [3];
  int q0 [$];
  int q1 [$];
  int q2 [$];

  typedef struct {
    int   cyc;
    logic busy;
    logic ps;
    int   sel;
    logic en;
    int   idx;
    logic last;
    logic done;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected accumulator tags: idx in bits 7:0, last flag in bit 8.
  task automatic sb_push(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      case (d)
        0: q0.push_back(i | ((i == n - 1) ? 256 : 0));
        1: q1.push_back(i | ((i == n - 1) ? 256 : 0));
        default: q2.push_back(i | ((i == n - 1) ? 256 : 0));
      endcase
    end
  endtask

  function automatic int sb_pop(input int d);
    int e;
    e = -1;
    case (d)
      0: if (q0.size() > 0) e = q0.pop_front();
      1: if (q1.size() > 0) e = q1.pop_front();
      default: if (q2.size() > 0) e = q2.pop_front();
    endcase
    return e;
  endfunction

  task automatic mon(input int d, input logic en, input int idx, input logic last, input logic dn);
    int e;
    if (dn === 1'b1) done_cnt[d]++;
    if (en === 1'b1) begin
      acc_cnt[d]++;
      e = sb_pop(d);
      if (e < 0) begin
        chk($sformatf("unexpected acc_en dut%0d", d), 1, 0);
      end else begin
        chk($sformatf("acc_idx dut%0d", d), idx, e & 255);
        chk($sformatf("acc_last dut%0d", d), int'(last), e >> 8);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, en_a, int'(idx_a), last_a, done_a);
    mon(1, en_b, int'(idx_b), last_b, done_b);
    mon(2, en_c, int'(idx_c), last_c, done_c);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base_done;

  initial begin
    nrst_a = 1'b1; nrst_bc = 1'b1;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    start_c = 1'b0; abort_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      acc_cnt[i] = 0;
    end
    tbl.push_back('{cyc:0,  busy:0, ps:0, sel:0,  en:0, idx:0,  last:0, done:0});
    tbl.push_back('{cyc:1,  busy:1, ps:1, sel:0,  en:0, idx:0,  last:0, done:0});
    tbl.push_back('{cyc:2,  busy:1, ps:1, sel:1,  en:1, idx:0,  last:0, done:0});
    tbl.push_back('{cyc:6,  busy:1, ps:1, sel:5,  en:1, idx:4,  last:0, done:0});
    tbl.push_back('{cyc:16, busy:1, ps:1, sel:15, en:1, idx:14, last:0, done:0});
    tbl.push_back('{cyc:28, busy:1, ps:1, sel:27, en:1, idx:26, last:0, done:0});
    tbl.push_back('{cyc:29, busy:1, ps:0, sel:27, en:1, idx:27, last:1, done:0});
    tbl.push_back('{cyc:30, busy:1, ps:0, sel:27, en:0, idx:0,  last:0, done:1});
    tbl.push_back('{cyc:31, busy:0, ps:0, sel:27, en:0, idx:0,  last:0, done:0});

    repeat (3) tick();
    chk("reset busy", busy_a, 0);
    chk("reset pack_sel", sel_a, 0);
    chk("reset pack_start", ps_a, 0);
    chk("reset acc_en", en_a, 0);
    chk("reset acc_idx", idx_a, 0);
    chk("reset acc_last", last_a, 0);
    chk("reset done", done_a, 0);
    nrst_a = 1'b0; nrst_bc = 1'b0;
    tick();

    // Full encode; starts at 5, 15 and on the done cycle must be ignored.
    sb_push(0, 28);
    for (int k = 0; k <= 31; k++) begin
      start_a = (k == 0 || k == 5 || k == 15 || k == 30);
      @(negedge clk);
      foreach (tbl[i]) begin
        if (tbl[i].cyc == k) begin
          chk($sformatf("t1 busy c%0d", k), busy_a, tbl[i].busy);
          chk($sformatf("t1 pack_start c%0d", k), ps_a, tbl[i].ps);
          chk($sformatf("t1 pack_sel c%0d", k), sel_a, tbl[i].sel);
          chk($sformatf("t1 acc_en c%0d", k), en_a, tbl[i].en);
          chk($sformatf("t1 done c%0d", k), done_a, tbl[i].done);
          if (tbl[i].en) begin
            chk($sformatf("t1 acc_idx c%0d", k), idx_a, tbl[i].idx);
            chk($sformatf("t1 acc_last c%0d", k), last_a, tbl[i].last);
          end
        end
      end
      tick();
    end
    start_a = 1'b0;
    chk("t1 done pulses", done_cnt[0], 1);
    chk("t1 acc_en pulses", acc_cnt[0], 28);
    chk("t1 scoreboard empty", q0.size(), 0);
`ifdef ENC_SCHED_PERF_EN
    chk("perf cycle_count", cc_a, 30);
    repeat (3) tick();
    chk("perf cycle_count hold", cc_a, 30);
`endif

    // Abort mid-encode, then a fresh encode from pack 0.
    base_done = done_cnt[0];
    for (int k = 0; k <= 43; k++) begin
      start_a = (k == 0 || k == 12);
      abort_a = (k == 10);
      if (k == 11) q0.delete();
      if (k == 0 || k == 12) sb_push(0, 28);
      @(negedge clk);
      if (k == 11) begin
        chk("abort busy", busy_a, 0);
        chk("abort pack_start", ps_a, 0);
        chk("abort acc_en", en_a, 0);
        chk("abort done", done_a, 0);
      end
      if (k == 13) begin
        chk("restart pack_start", ps_a, 1);
        chk("restart pack_sel", sel_a, 0);
      end
      if (k == 41) chk("restart done early", done_a, 0);
      if (k == 42) chk("restart done", done_a, 1);
      tick();
    end
    start_a = 1'b0; abort_a = 1'b0;
    chk("abort done pulses", done_cnt[0] - base_done, 1);
    chk("abort scoreboard empty", q0.size(), 0);

    // start & abort together in IDLE: abort wins.
    for (int k = 0; k <= 3; k++) begin
      start_a = (k == 0);
      abort_a = (k == 0);
      @(negedge clk);
      if (k >= 1) begin
        chk($sformatf("idle abort busy c%0d", k), busy_a, 0);
        chk($sformatf("idle abort pack_start c%0d", k), ps_a, 0);
      end
      tick();
    end
    start_a = 1'b0; abort_a = 1'b0;

    // Reset mid-encode.
    for (int k = 0; k <= 18; k++) begin
      start_a = (k == 0);
      nrst_a = (k == 15);
      if (k == 0) sb_push(0, 28);
      if (k == 16) q0.delete();
      @(negedge clk);
      if (k == 14) chk("pre-reset busy", busy_a, 1);
      if (k == 16) begin
        chk("mid reset busy", busy_a, 0);
        chk("mid reset pack_sel", sel_a, 0);
        chk("mid reset pack_start", ps_a, 0);
        chk("mid reset acc_en", en_a, 0);
        chk("mid reset acc_idx", idx_a, 0);
        chk("mid reset acc_last", last_a, 0);
        chk("mid reset done", done_a, 0);
`ifdef ENC_SCHED_PERF_EN
        chk("mid reset cycle_count", cc_a, 0);
`endif
      end
      tick();
    end
    start_a = 1'b0; nrst_a = 1'b0;

    // NUM_PACKS=4, BIND_LAT=3.
    sb_push(1, 4);
    for (int k = 0; k <= 10; k++) begin
      start_b = (k == 0);
      @(negedge clk);
      chk($sformatf("b busy c%0d", k), busy_b, (k >= 1 && k <= 8));
      chk($sformatf("b pack_start c%0d", k), ps_b, (k >= 1 && k <= 4));
      chk($sformatf("b acc_en c%0d", k), en_b, (k >= 4 && k <= 7));
      chk($sformatf("b done c%0d", k), done_b, (k == 8));
      if (k >= 1 && k <= 4) chk($sformatf("b pack_sel c%0d", k), sel_b, k - 1);
      tick();
    end
    start_b = 1'b0;
    chk("b acc_en pulses", acc_cnt[1], 4);
    chk("b done pulses", done_cnt[1], 1);
`ifdef ENC_SCHED_PERF_EN
    chk("b cycle_count", cc_b, 8);
`endif

    // NUM_PACKS=1.
    sb_push(2, 1);
    for (int k = 0; k <= 5; k++) begin
      start_c = (k == 0);
      @(negedge clk);
      chk($sformatf("c busy c%0d", k), busy_c, (k >= 1 && k <= 3));
      chk($sformatf("c pack_start c%0d", k), ps_c, (k == 1));
      chk($sformatf("c acc_en c%0d", k), en_c, (k == 2));
      chk($sformatf("c done c%0d", k), done_c, (k == 3));
      if (k == 2) chk("c acc_last", last_c, 1);
      tick();
    end
    start_c = 1'b0;
    chk("c acc_en pulses", acc_cnt[2], 1);
`ifdef ENC_SCHED_PERF_EN
    chk("c cycle_count", cc_c, 3);
`endif

    chk("final q0 empty", q0.size(), 0);
    chk("final q1 empty", q1.size(), 0);
    chk("final q2 empty", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
